mac_vector_feeder: RTL and testbench
====================================

Name: mac_vector_feeder

Overview:
Upstream operand sequencer for the MAC stage. Holds a reusable weight vector of up to MAX_LEN elements and streams input vectors against it. For each element it drives the MAC's En/Clr/Ain/Bin controls, then captures the accumulated Cout as one dot-product result per input vector. Together with MAC it forms a matrix-vector row engine: load weights once, stream many x vectors.

Parameters:
DATA_WIDTH, 8, operand width; must match MAC DATA_WIDTH
MAX_LEN, 8, weight buffer depth (maximum vector length)
LEN_W, $clog2(MAX_LEN+1), width of the length field

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
cfg_valid  input  1  new vector length offered
cfg_len  input  LEN_W  vector length for the following weight load
cfg_ready  output  1  length accepted when cfg_valid & cfg_ready
w_valid  input  1  weight element valid
w_data  input  DATA_WIDTH  weight element, index order 0..len-1
w_ready  output  1  weight accepted on w_valid & w_ready
x_valid  input  1  input-vector element valid
x_data  input  DATA_WIDTH  input element, index order 0..len-1
x_ready  output  1  input element accepted on x_valid & x_ready
mac_en  output  1  to MAC En
mac_clr  output  1  to MAC Clr
mac_ain  output  DATA_WIDTH  to MAC Ain (weight)
mac_bin  output  DATA_WIDTH  to MAC Bin (input element)
mac_cout  input  3*DATA_WIDTH  from MAC Cout
res_valid  output  1  dot-product result valid
res_data  output  3*DATA_WIDTH  captured result
res_ready  input  1  result consumed on res_valid & res_ready

Behaviour:
- Reset (async, immediate): state IDLE, len=0, idx=0, weights invalid. Every output 0 (cfg_ready=1 only after reset releases, since it is decoded from IDLE).
- The MAC accumulates unsigned A*B on a posedge with En; Clr clears on a posedge and has priority over En. The feeder never asserts both.
- States: IDLE, LOAD, CLR, RUN, DRAIN, RESULT.
- IDLE: cfg_ready=1. An accepted cfg with len 0 stays in IDLE. Any other accepted cfg latches len and moves to LOAD. cfg_len > MAX_LEN saturates to MAX_LEN.
- LOAD: w_ready=1. Each accepted w_data is written to buf[idx] and idx increments. After accepting element len-1: idx=0, go to CLR.
- CLR: one cycle with mac_clr=1. cfg_ready=1 in this state; an accepted cfg goes to LOAD (or IDLE if len 0). Otherwise go to RUN.
- RUN: x_ready=1. Accept handshake is combinational in the same cycle: mac_en = x_valid & x_ready, mac_ain=buf[idx], mac_bin=x_data, and idx increments. On accepting element len-1: idx=0, go to DRAIN. cfg_ready=1 only while idx==0, with the same transition as in CLR.
- DRAIN: one cycle. On its closing edge, res_data <= mac_cout; go to RESULT.
- RESULT: res_valid=1 and res_data held stable. x_ready=w_ready=cfg_ready=0. On res_ready go to CLR; weights are retained for the next vector.
- mac_ain/mac_bin are 0 whenever mac_en=0. mac_clr is 1 only in CLR.
- Latency: last x accepted in cycle k, MAC updates at end of k, DRAIN is k+1, res_valid rises at cycle k+2. Per-vector cost is len + 3 cycles minimum.
- Result width is 3*DATA_WIDTH with no saturation. The full-scale MAX_LEN=8 sum fits.
- x_valid gaps: idx holds and mac_en=0. Inputs not handshaken are ignored; no overflow is possible.
- rst mid-operation aborts the partial dot product and invalidates the weights. A new cfg plus weight load is required.

Test Plan:
- Load: cfg_len=3, weights 2,4,8; then x=2,4,0 back-to-back -> one mac_clr pulse before the first x; res_data=20 (0x000014); res_valid 2 cycles after the third x.
- Weight reuse: after the result is taken with res_ready=1, send x=1,1,1 -> mac_clr pulses again; res_data=14; no reload needed.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid=1, res_data=20 stable, x_ready=0, mac_en=0 throughout. Then res_ready=1 -> exactly one transfer.
- Full scale: cfg_len=8, all weights 0xFF, x all 0xFF with random x_valid gaps -> res_data=520200 (0x07F008); mac_en count equals 8.
- Length edge cases: cfg_len=10 -> clamps to 8 (w_ready drops after 8 weights). cfg_len=0 -> stays IDLE with x_ready=0.
- Reset mid-RUN after 2 of 3 x -> all outputs 0 immediately. After release, x_ready=0 until a new cfg and 3 weights are loaded. Next vector 1,1,1 with weights 1,1,1 -> res_data=3.

Source files
------------

// File: rtl/mac_vector_feeder.sv
// Operand sequencer for the MAC stage: holds a weight vector and streams
// input vectors against it, capturing one dot product per input vector.
module mac_vector_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 8,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  input  logic [LEN_W-1:0]        cfg_len,
  output logic                    cfg_ready,
  input  logic                    w_valid,
  input  logic [DATA_WIDTH-1:0]   w_data,
  output logic                    w_ready,
  input  logic                    x_valid,
  input  logic [DATA_WIDTH-1:0]   x_data,
  output logic                    x_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_ain,
  output logic [DATA_WIDTH-1:0]   mac_bin,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  output logic [3*DATA_WIDTH-1:0] res_data,
  input  logic                    res_ready
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    RUN,
    DRAIN,
    RESULT
  } state_t;

  state_t                  state;
  logic [LEN_W-1:0]        len;
  logic [LEN_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   wbuf [MAX_LEN];
  logic [3*DATA_WIDTH-1:0] res_q;

  logic             cfg_fire;
  logic             w_fire;
  logic             x_fire;
  logic             last;
  logic [LEN_W-1:0] len_sat;

  // cfg_ready is gated by rst so it stays low while reset is held
  assign cfg_ready = !rst &&
                     (state == IDLE || state == CLR ||
                      (state == RUN && idx == '0));
  assign w_ready   = (state == LOAD);
  assign x_ready   = (state == RUN);
  assign mac_clr   = (state == CLR);
  assign res_valid = (state == RESULT);
  assign res_data  = res_q;

  assign cfg_fire = cfg_valid & cfg_ready;
  assign w_fire   = w_valid & w_ready;
  assign x_fire   = x_valid & x_ready;
  assign mac_en   = x_fire;
  assign mac_ain  = mac_en ? wbuf[idx[IW-1:0]] : '0;
  assign mac_bin  = mac_en ? x_data : '0;

  assign last    = (idx == len - LEN_W'(1));
  assign len_sat = (cfg_len > LEN_W'(MAX_LEN)) ?
                   LEN_W'(MAX_LEN) : cfg_len;

  always_ff @(posedge clk) begin
    if (w_fire) begin
      wbuf[idx[IW-1:0]] <= w_data;
    end
  end

  // A new cfg takes precedence over streaming once the vector is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_fire) begin
            len   <= len_sat;
            idx   <= '0;
            state <= (len_sat == '0) ? IDLE : LOAD;
          end
        end
        LOAD: begin
          if (w_fire) begin
            if (last) begin
              idx   <= '0;
              state <= CLR;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        CLR: begin
          if (cfg_fire) begin
            len   <= len_sat;
            idx   <= '0;
            state <= (len_sat == '0) ? IDLE : LOAD;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (cfg_fire) begin
            len   <= len_sat;
            idx   <= '0;
            state <= (len_sat == '0) ? IDLE : LOAD;
          end else if (x_fire) begin
            if (last) begin
              idx   <= '0;
              state <= DRAIN;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          res_q <= mac_cout;
          state <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            state <= CLR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Directed bench for mac_vector_feeder with a behavioural MAC model
// closing the loop from mac_en/mac_clr back to mac_cout.
module tb_mac_vector_feeder;

  localparam int DW = 8;
  localparam int ML = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [LW-1:0] cfg_len;
  logic          cfg_ready;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          x_valid;
  logic [DW-1:0] x_data;
  logic          x_ready;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_ain;
  logic [DW-1:0] mac_bin;
  logic [3*DW-1:0] mac_cout;
  logic          res_valid;
  logic [3*DW-1:0] res_data;
  logic          res_ready;

  always #5 clk = ~clk;

  mac_vector_feeder #(
    .DATA_WIDTH(DW),
    .MAX_LEN(ML),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_len(cfg_len),
    .cfg_ready(cfg_ready),
    .w_valid(w_valid),
    .w_data(w_data),
    .w_ready(w_ready),
    .x_valid(x_valid),
    .x_data(x_data),
    .x_ready(x_ready),
    .mac_en(mac_en),
    .mac_clr(mac_clr),
    .mac_ain(mac_ain),
    .mac_bin(mac_bin),
    .mac_cout(mac_cout),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_ready(res_ready)
  );

  // MAC: clear has priority over accumulate
  always @(posedge clk or posedge rst) begin
    if (rst) mac_cout <= '0;
    else if (mac_clr) mac_cout <= '0;
    else if (mac_en)
      mac_cout <= mac_cout + (24'(mac_ain) * 24'(mac_bin));
  end

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (mac_en) en_cnt++;
    if (mac_clr) clr_cnt++;
    if (mac_en && mac_clr) both_cnt++;
  end

  typedef struct {
    int              cl;
    int              n;
    bit              reload;
    logic [7:0][7:0] w;
    logic [7:0][7:0] x;
    logic [7:0]      gap;
    int              hold;
    logic [23:0]     exp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int l);
    bit ok = 1'b0;
    cfg_valid = 1'b1;
    cfg_len   = LW'(l);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    cfg_valid = 1'b0;
    chk("cfg_handshake", 64'(ok), 64'd1);
  endtask

  task automatic send_w(input logic [7:0] d);
    bit ok = 1'b0;
    w_valid = 1'b1;
    w_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (w_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    w_valid = 1'b0;
    chk("w_handshake", 64'(ok), 64'd1);
  endtask

  task automatic send_x(input logic [7:0] w, input logic [7:0] d);
    bit ok = 1'b0;
    x_valid = 1'b1;
    x_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (x_ready) begin
        ok = 1'b1;
        chk("x_mac_en", 64'(mac_en), 64'd1);
        chk("x_mac_ain", 64'(mac_ain), 64'(w));
        chk("x_mac_bin", 64'(mac_bin), 64'(d));
        break;
      end
    end
    tick();
    x_valid = 1'b0;
    chk("x_handshake", 64'(ok), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int cb;
    int eb;
    if (v.reload) begin
      do_cfg(v.cl);
      for (int i = 0; i < v.n; i++) send_w(v.w[i]);
      chk("w_ready_stop", 64'(w_ready), 64'd0);
    end
    cb = clr_cnt;
    eb = en_cnt;
    for (int i = 0; i < v.n; i++) begin
      if (v.gap[i]) begin
        x_valid = 1'b0;
        x_data  = 8'hAA;
        @(negedge clk);
        chk("gap_mac_en", 64'(mac_en), 64'd0);
        chk("gap_mac_bin", 64'(mac_bin), 64'd0);
        tick();
      end
      send_x(v.w[i], v.x[i]);
    end
    chk("clr_pulses", 64'(clr_cnt - cb), 64'd1);
    chk("en_count", 64'(en_cnt - eb), 64'(v.n));
    chk("drain_not_valid", 64'(res_valid), 64'd0);
    tick();
    chk("res_valid_latency", 64'(res_valid), 64'd1);
    chk("res_data", 64'(res_data), 64'(v.exp));
    for (int h = 0; h < v.hold; h++) begin
      x_valid = 1'b1;
      x_data  = 8'h55;
      #1;
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(v.exp));
      chk("hold_xr_en", 64'({x_ready, mac_en, w_ready, cfg_ready}), 64'd0);
      tick();
    end
    x_valid   = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("one_transfer", 64'(res_valid), 64'd0);
  endtask

  function automatic vec_t mk(input int cl, input int n, input bit rl,
                              input int hold, input logic [23:0] exp);
    vec_t v;
    v.cl = cl;
    v.n = n;
    v.reload = rl;
    v.w = '0;
    v.x = '0;
    v.gap = '0;
    v.hold = hold;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(3, 3, 1'b1, 5, 24'd20);
    tbl[0].w[0] = 8'd2; tbl[0].w[1] = 8'd4; tbl[0].w[2] = 8'd8;
    tbl[0].x[0] = 8'd2; tbl[0].x[1] = 8'd4; tbl[0].x[2] = 8'd0;
    tbl[1] = mk(3, 3, 1'b0, 0, 24'd14);
    tbl[1].w = tbl[0].w;
    for (int i = 0; i < 3; i++) tbl[1].x[i] = 8'd1;
    tbl[2] = mk(2, 2, 1'b1, 0, 24'd66);
    tbl[2].w[0] = 8'd3; tbl[2].w[1] = 8'd5;
    tbl[2].x[0] = 8'd7; tbl[2].x[1] = 8'd9;
    tbl[3] = mk(8, 8, 1'b1, 0, 24'h07F008);
    for (int i = 0; i < 8; i++) begin
      tbl[3].w[i] = 8'hFF;
      tbl[3].x[i] = 8'hFF;
    end
    tbl[3].gap = 8'($urandom_range(1, 255));
    tbl[4] = mk(10, 8, 1'b1, 0, 24'd36);
    for (int i = 0; i < 8; i++) begin
      tbl[4].w[i] = 8'd1;
      tbl[4].x[i] = 8'(i + 1);
    end
    tbl[5] = mk(3, 3, 1'b1, 0, 24'd3);
    for (int i = 0; i < 3; i++) begin
      tbl[5].w[i] = 8'd1;
      tbl[5].x[i] = 8'd1;
    end

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_len = '0;
    w_valid = 1'b0; w_data = '0;
    x_valid = 1'b0; x_data = '0;
    res_ready = 1'b0;
    #2;
    chk("reset_outputs",
        64'({cfg_ready, w_ready, x_ready, mac_en, mac_clr, res_valid,
             mac_ain, mac_bin, res_data}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("cfg_ready_after_reset", 64'(cfg_ready), 64'd1);
    chk("x_ready_idle", 64'(x_ready), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    do_cfg(0);
    x_valid = 1'b1;
    x_data  = 8'h11;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("len0_idle_ready", 64'({cfg_ready, w_ready, x_ready, mac_en}),
          64'b1000);
      tick();
    end
    x_valid = 1'b0;

    do_cfg(3);
    send_w(8'd2);
    send_w(8'd4);
    send_w(8'd8);
    send_x(8'd2, 8'd2);
    send_x(8'd4, 8'd4);
    x_valid = 1'b1;
    x_data  = 8'd9;
    rst = 1'b1;
    #1;
    chk("midrun_reset_outputs",
        64'({cfg_ready, w_ready, x_ready, mac_en, mac_clr, res_valid,
             mac_ain, mac_bin, res_data}), 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("post_reset_idle", 64'({cfg_ready, x_ready, mac_en}), 64'b100);
      tick();
    end
    x_valid = 1'b0;

    run_vec(tbl[5]);
    chk("clr_en_overlap", 64'(both_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
